// File: rtl/axi_lite_pkg.sv
// Purpose: shared response codes and FSM state types for the AXI4-Lite register-file slave.
// Latency: none (types and constants only).
// Backpressure: none.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_RESP  = 2'd2
    } rd_state_t;

    // A word index addresses a real register only below the register count.
    function automatic logic idx_in_range(input logic [31:0] idx, input int num_regs);
        return idx < 32'(num_regs);
    endfunction

endpackage

// File: rtl/axi_lite_reg_file_slave.sv
// Purpose: AXI4-Lite slave turning bus writes/reads into single-cycle register-file port accesses.
// Latency: write strobe + bvalid 1 cycle after last AW/W handshake; read strobe +1, rvalid +2 after AR.
// Backpressure: one outstanding write and one read; readies stay low until the B/R handshake completes.
module axi_lite_reg_file_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,

    input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,

    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,

    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,

    output logic                          reg_wr_en,
    output logic [$clog2(NUM_REGS)-1:0]   reg_wr_idx,
    output logic [DATA_WIDTH-1:0]         reg_wr_data,
    output logic [DATA_WIDTH/8-1:0]       reg_wr_strb,

    output logic                          reg_rd_en,
    output logic [$clog2(NUM_REGS)-1:0]   reg_rd_idx,
    input  logic [DATA_WIDTH-1:0]         reg_rd_data
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    // Byte offset bits carry no meaning: unaligned addresses hit the containing word.
    logic unused_byte_offsets;
    assign unused_byte_offsets = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] aw_word;
    logic [WORD_W-1:0] ar_word;
    logic              aw_in_range;
    logic              ar_in_range;

    assign aw_word     = s_axi_awaddr[ADDR_WIDTH-1:2];
    assign ar_word     = s_axi_araddr[ADDR_WIDTH-1:2];
    // Range is judged on the full word index so that high addresses never alias low registers.
    assign aw_in_range = idx_in_range(32'(aw_word), NUM_REGS);
    assign ar_in_range = idx_in_range(32'(ar_word), NUM_REGS);

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_t         wr_state_q, wr_state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              wr_oor_q, wr_oor_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              wr_en_q, wr_en_d;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid && wready_q;

    // Write FSM: collect AW and W independently, then issue the strobe and the B response together.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_oor_d   = wr_oor_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_en_d    = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    wr_idx_d  = aw_word[IDX_W-1:0];
                    wr_oor_d  = !aw_in_range;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    wr_state_d = W_RESP;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_oor_d ? RESP_SLVERR : RESP_OKAY;
                    wr_en_d    = !wr_oor_d;
                end else begin
                    // Each ready drops as soon as its own channel has been captured.
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
                bvalid_d   = 1'b0;
            end
        endcase
    end

    // Write path registers; readies reset low and rise on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_oor_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_en_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            wr_idx_q   <= wr_idx_d;
            wr_oor_q   <= wr_oor_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_en_q    <= wr_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_t         rd_state_q, rd_state_d;
    logic              arready_q, arready_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              rd_oor_q, rd_oor_d;
    logic              rd_en_q, rd_en_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_first_q, rd_first_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rd_fetch_data;

    logic ar_hs;

    assign ar_hs = s_axi_arvalid && arready_q;

    // The register file answers one cycle after the strobe, i.e. during the first rvalid cycle.
    // That cycle passes the returned word straight through and latches it, so later changes on
    // reg_rd_data never reach rdata while the response waits for rready.
    assign rd_fetch_data = rd_oor_q ? '0 : reg_rd_data;

    // Read FSM: accept AR, strobe the register file, then hold the response until rready.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_oor_d   = rd_oor_q;
        rd_en_d    = 1'b0;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rd_first_d = 1'b0;
        rdata_d    = rdata_q;

        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rd_state_d = R_FETCH;
                    arready_d  = 1'b0;
                    rd_idx_d   = ar_word[IDX_W-1:0];
                    rd_oor_d   = !ar_in_range;
                    rd_en_d    = ar_in_range;
                end
            end
            R_FETCH: begin
                rd_state_d = R_RESP;
                rvalid_d   = 1'b1;
                rresp_d    = rd_oor_q ? RESP_SLVERR : RESP_OKAY;
                rd_first_d = 1'b1;
            end
            R_RESP: begin
                if (rd_first_q) begin
                    rdata_d = rd_fetch_data;
                end
                if (rvalid_q && s_axi_rready) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rvalid_d   = 1'b0;
            end
        endcase
    end

    // Read path registers; arready resets low and rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rd_idx_q   <= '0;
            rd_oor_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rd_first_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rd_idx_q   <= rd_idx_d;
            rd_oor_q   <= rd_oor_d;
            rd_en_q    <= rd_en_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rd_first_q <= rd_first_d;
            rdata_q    <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rd_first_q ? rd_fetch_data : rdata_q;

    assign reg_wr_en     = wr_en_q;
    assign reg_wr_idx    = wr_idx_q;
    assign reg_wr_data   = wdata_q;
    assign reg_wr_strb   = wstrb_q;

    assign reg_rd_en     = rd_en_q;
    assign reg_rd_idx    = rd_idx_q;

endmodule
